// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB request arbiter.
package sccb_pkg;
  localparam logic [7:0] SCCB_DEV_ADDR = 8'h42;
  localparam int REQ_W = 16;
  localparam int ENG_W = 24;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    GAP,
    RESP
  } state_t;
endpackage

// File: rtl/sccb_arbiter_if.sv
// Requester, engine and debug signals of the SCCB arbiter.
interface sccb_arbiter_if;
  import sccb_pkg::*;

  // Handshake: x_valid/x_data are held by the requester until x_ready pulses;
  // a request withdrawn before x_ready is dropped. Exactly one x_done or x_err
  // pulse follows every x_ready.
  logic             a_valid;
  logic [REQ_W-1:0] a_data;
  logic             a_ready;
  logic             a_done;
  logic             a_err;
  logic             b_valid;
  logic [REQ_W-1:0] b_data;
  logic             b_ready;
  logic             b_done;
  logic             b_err;
  logic             lock_a;
  logic             eng_en;
  logic [ENG_W-1:0] eng_data;
  logic             eng_end;
  logic             eng_nack;
  logic             busy;
  state_t           dbg_state;
  logic             dbg_prio;

  modport slave (
    input  a_valid, a_data, b_valid, b_data, lock_a, eng_end, eng_nack,
    output a_ready, a_done, a_err, b_ready, b_done, b_err,
           eng_en, eng_data, busy, dbg_state, dbg_prio
  );

  modport master (
    output a_valid, a_data, b_valid, b_data, lock_a, eng_end, eng_nack,
    input  a_ready, a_done, a_err, b_ready, b_done, b_err,
           eng_en, eng_data, busy, dbg_state, dbg_prio
  );
endinterface

// File: rtl/sccb_rr_arbiter.sv
// Two-requester round robin; prio=0 favours A, prio=1 favours B.
module sccb_rr_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       mask_b,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       prio
);
  logic [1:0] elig;

  assign elig = {req[1] & ~mask_b, req[0]};

  always_comb begin
    grant = 2'b00;
    if (prio && elig[1])
      grant = 2'b10;
    else if (elig[0])
      grant = 2'b01;
    else if (elig[1])
      grant = 2'b10;
  end

  // Priority moves to whichever requester was not just granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      prio <= 1'b0;
    else if (advance && (grant != 2'b00))
      prio <= grant[0];
  end
endmodule

// File: rtl/sccb_arbiter.sv
// Arbitrates two register-write requesters onto one SCCB engine with retry and timeout.
module sccb_arbiter
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR    = SCCB_DEV_ADDR,
  parameter int         MAX_RETRY   = 3,
  parameter int         GAP_CYC     = 8,
  parameter int         TIMEOUT_CYC = 4096
) (
  input logic           clk,
  input logic           reset,
  sccb_arbiter_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_CYC - 1);
  localparam logic [RW-1:0] R_LAST = RW'(MAX_RETRY - 1);

  state_t           state, state_nx;
  logic [1:0]       grant;
  logic             prio;
  logic             advance, fin_ok, fin_err;
  logic             owner;
  logic [TW-1:0]    tcnt;
  logic [GW-1:0]    gcnt;
  logic [RW-1:0]    att;
  logic [ENG_W-1:0] eng_data_q;
  logic             a_ready_q, a_done_q, a_err_q, b_ready_q, b_done_q, b_err_q;

  sccb_rr_arbiter u_rr (
    .clk    (clk),
    .reset  (reset),
    .req    ({bus.b_valid, bus.a_valid}),
    .mask_b (bus.lock_a),
    .advance(advance),
    .grant  (grant),
    .prio   (prio)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // eng_end is only looked at in XFER, and wins over a same-cycle timeout.
  always_comb begin
    state_nx = state;
    advance  = 1'b0;
    fin_ok   = 1'b0;
    fin_err  = 1'b0;
    case (state)
      IDLE: if (grant != 2'b00) begin
        advance  = 1'b1;
        state_nx = XFER;
      end
      XFER: begin
        if (bus.eng_end) begin
          if (!bus.eng_nack) begin
            fin_ok   = 1'b1;
            state_nx = RESP;
          end else if (att == R_LAST) begin
            fin_err  = 1'b1;
            state_nx = RESP;
          end else begin
            state_nx = GAP;
          end
        end else if (tcnt == T_LAST) begin
          fin_err  = 1'b1;
          state_nx = RESP;
        end
      end
      GAP:     if (gcnt == G_LAST) state_nx = XFER;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner      <= 1'b0;
      eng_data_q <= '0;
      att        <= '0;
      tcnt       <= '0;
      gcnt       <= '0;
      a_ready_q  <= 1'b0;
      a_done_q   <= 1'b0;
      a_err_q    <= 1'b0;
      b_ready_q  <= 1'b0;
      b_done_q   <= 1'b0;
      b_err_q    <= 1'b0;
    end else begin
      a_ready_q <= advance & grant[0];
      b_ready_q <= advance & grant[1];
      a_done_q  <= fin_ok & ~owner;
      a_err_q   <= fin_err & ~owner;
      b_done_q  <= fin_ok & owner;
      b_err_q   <= fin_err & owner;
      if (advance) begin
        owner      <= grant[1];
        eng_data_q <= {DEV_ADDR, grant[1] ? bus.b_data : bus.a_data};
        att        <= '0;
      end else if (state == XFER && bus.eng_end && bus.eng_nack) begin
        att <= att + 1'b1;
      end
      // Timeout counter restarts on every entry to XFER, from IDLE or GAP.
      tcnt <= (state == XFER) ? tcnt + 1'b1 : '0;
      gcnt <= (state == GAP) ? gcnt + 1'b1 : '0;
    end
  end

  assign bus.eng_en    = (state == XFER);
  assign bus.eng_data  = eng_data_q;
  assign bus.busy      = (state != IDLE);
  assign bus.a_ready   = a_ready_q;
  assign bus.a_done    = a_done_q;
  assign bus.a_err     = a_err_q;
  assign bus.b_ready   = b_ready_q;
  assign bus.b_done    = b_done_q;
  assign bus.b_err     = b_err_q;
  assign bus.dbg_state = state;
  assign bus.dbg_prio  = prio;
endmodule

// File: tb/tb_sccb_arbiter.sv
// Directed scoreboard bench for sccb_arbiter (MAX_RETRY=3, GAP_CYC=8, TIMEOUT_CYC=64).
module tb_sccb_arbiter;
  import sccb_pkg::*;

  localparam int W = 28;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sccb_arbiter_if bus ();

  sccb_arbiter #(
    .DEV_ADDR   (8'h42),
    .MAX_RETRY  (3),
    .GAP_CYC    (8),
    .TIMEOUT_CYC(64)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int lo_run = 0;
  int hi_run = 0;
  int last_hi = 0;
  int rise_cnt = 0;
  int lo_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic ad, input logic ae, input logic bd,
                                      input logic be, input logic [23:0] d);
    return {ad, ae, bd, be, d};
  endfunction

  // Monitor: eng_en run lengths and completion pulses against the expected queue.
  always @(negedge clk) begin
    logic [W-1:0] act, e;
    if (reset) begin
      lo_run = 0;
      hi_run = 0;
    end else begin
      if (bus.eng_en) begin
        if (hi_run == 0) begin
          lo_q.push_back(lo_run);
          rise_cnt++;
        end
        hi_run++;
        lo_run = 0;
      end else begin
        if (hi_run != 0) last_hi = hi_run;
        hi_run = 0;
        lo_run++;
      end
      if (bus.a_done | bus.a_err | bus.b_done | bus.b_err) begin
        act = {bus.a_done, bus.a_err, bus.b_done, bus.b_err, bus.eng_data};
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp: got %h expected none", act);
        end else begin
          e = exp_q.pop_front();
          check("resp", 32'(act), 32'(e));
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input bit is_b, input int max, output int lat);
    lat = 0;
    while (lat < max) begin
      tick();
      lat++;
      if (is_b ? bus.b_ready : bus.a_ready) break;
    end
    if (!(is_b ? bus.b_ready : bus.a_ready)) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got none expected %s_ready", is_b ? "b" : "a");
      lat = -1;
    end
  endtask

  // Engine model: pulse eng_end during the cyc-th cycle of the current eng_en window.
  task automatic engine(input int cyc, input bit nack, input int max_wait);
    int w = 0;
    while (!bus.eng_en && w < max_wait) begin
      tick();
      w++;
    end
    if (!bus.eng_en) begin
      total++;
      bad++;
      $display("FAIL eng_en_timeout: got 0 expected 1");
      return;
    end
    repeat (cyc - 1) tick();
    bus.eng_end  = 1'b1;
    bus.eng_nack = nack;
    tick();
    bus.eng_end  = 1'b0;
    bus.eng_nack = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (bus.busy && n < max) begin
      tick();
      n++;
    end
    if (bus.busy) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got busy=1 expected 0");
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int lat, r0;
    bit seen;
    bus.a_valid  = 1'b0;
    bus.a_data   = '0;
    bus.b_valid  = 1'b0;
    bus.b_data   = '0;
    bus.lock_a   = 1'b0;
    bus.eng_end  = 1'b0;
    bus.eng_nack = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_eng_en", 32'(bus.eng_en), 32'd0);
    check("rst_eng_data", 32'(bus.eng_data), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_pulses", 32'({bus.a_ready, bus.a_done, bus.a_err, bus.b_ready, bus.b_done, bus.b_err}), 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'(IDLE));
    check("rst_prio", 32'(bus.dbg_prio), 32'd0);
    reset = 1'b0;
    tick();

    // Single A write, ACK after 50 cycles
    bus.a_data  = 16'h1204;
    bus.a_valid = 1'b1;
    exp_q.push_back(mk(1, 0, 0, 0, 24'h421204));
    wait_ready(0, 4, lat);
    check("a_ready_lat", 32'(lat), 32'd1);
    bus.a_valid = 1'b0;
    check("xfer_eng_en", 32'(bus.eng_en), 32'd1);
    check("xfer_eng_data", 32'(bus.eng_data), 32'h421204);
    check("xfer_busy", 32'(bus.busy), 32'd1);
    engine(50, 0, 4);
    check("ack_window", 32'(last_hi), 32'd50);
    tick();
    check("busy_after_resp", 32'(bus.busy), 32'd0);

    // Stray eng_end while idle
    r0 = rise_cnt;
    bus.eng_end = 1'b1;
    tick();
    bus.eng_end = 1'b0;
    tick();
    check("stray_end_busy", 32'(bus.busy), 32'd0);
    check("stray_end_rise", 32'(rise_cnt), 32'(r0));

    // Round robin after reset: A first, then B while A contends again
    do_reset();
    bus.a_data  = 16'h0a01;
    bus.b_data  = 16'h0b02;
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    exp_q.push_back(mk(1, 0, 0, 0, 24'h420a01));
    wait_ready(0, 4, lat);
    check("rr_a_first_lat", 32'(lat), 32'd1);
    check("rr_b_waits", 32'(bus.b_ready), 32'd0);
    bus.a_valid = 1'b0;
    engine(5, 0, 4);
    bus.a_data  = 16'h0a03;
    bus.a_valid = 1'b1;
    exp_q.push_back(mk(0, 0, 1, 0, 24'h420b02));
    exp_q.push_back(mk(1, 0, 0, 0, 24'h420a03));
    wait_ready(1, 8, lat);
    check("rr_b_second", 32'(bus.a_ready), 32'd0);
    check("rr_low_gap_min2", 32'(lo_q[$] >= 2), 32'd1);
    bus.b_valid = 1'b0;
    engine(5, 0, 4);
    wait_ready(0, 8, lat);
    check("rr_a_third", 32'(lat > 0), 32'd1);
    bus.a_valid = 1'b0;
    engine(5, 0, 4);
    wait_idle(10);

    // lock_a masks B
    bus.lock_a  = 1'b1;
    bus.b_data  = 16'h1357;
    bus.b_valid = 1'b1;
    r0 = rise_cnt;
    seen = 1'b0;
    repeat (1000) begin
      tick();
      if (bus.b_ready || bus.eng_en) seen = 1'b1;
    end
    check("lock_no_grant", 32'(seen), 32'd0);
    check("lock_no_window", 32'(rise_cnt), 32'(r0));
    exp_q.push_back(mk(0, 0, 1, 0, 24'h421357));
    bus.lock_a = 1'b0;
    wait_ready(1, 4, lat);
    check("unlock_b_lat", 32'(lat), 32'd1);
    bus.b_valid = 1'b0;
    engine(7, 0, 4);
    wait_idle(10);

    // NACK on every attempt: three windows, 8 low cycles between, one err
    bus.a_data  = 16'h3a5c;
    bus.a_valid = 1'b1;
    exp_q.push_back(mk(0, 1, 0, 0, 24'h423a5c));
    r0 = rise_cnt;
    wait_ready(0, 4, lat);
    bus.a_valid = 1'b0;
    repeat (3) engine(4, 1, 16);
    wait_idle(10);
    repeat (12) tick();
    check("retry_windows", 32'(rise_cnt - r0), 32'd3);
    check("retry_gap1", 32'(lo_q[$-1]), 32'd8);
    check("retry_gap2", 32'(lo_q[$]), 32'd8);

    // Timeout with no eng_end; a B request withdrawn before ready is dropped
    bus.a_data  = 16'h5501;
    bus.a_valid = 1'b1;
    exp_q.push_back(mk(0, 1, 0, 0, 24'h425501));
    wait_ready(0, 4, lat);
    bus.a_valid = 1'b0;
    bus.b_data  = 16'hdead;
    bus.b_valid = 1'b1;
    repeat (3) tick();
    bus.b_valid = 1'b0;
    wait_idle(100);
    check("timeout_window", 32'(last_hi), 32'd64);
    r0 = rise_cnt;
    repeat (4) tick();
    check("dropped_b_busy", 32'(bus.busy), 32'd0);
    check("dropped_b_window", 32'(rise_cnt), 32'(r0));

    // eng_end on the last cycle before timeout wins
    bus.a_data  = 16'h5502;
    bus.a_valid = 1'b1;
    exp_q.push_back(mk(1, 0, 0, 0, 24'h425502));
    wait_ready(0, 4, lat);
    bus.a_valid = 1'b0;
    engine(64, 0, 4);
    check("late_ack_window", 32'(last_hi), 32'd64);
    wait_idle(10);

    // Asynchronous reset during XFER aborts silently, priority back to A
    bus.a_data  = 16'h7777;
    bus.a_valid = 1'b1;
    wait_ready(0, 4, lat);
    bus.a_valid = 1'b0;
    repeat (10) tick();
    check("pre_abort_eng_en", 32'(bus.eng_en), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("abort_eng_en", 32'(bus.eng_en), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    bus.a_data  = 16'h0101;
    bus.b_data  = 16'h0202;
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    exp_q.push_back(mk(1, 0, 0, 0, 24'h420101));
    wait_ready(0, 4, lat);
    check("post_rst_a_lat", 32'(lat), 32'd1);
    check("post_rst_b_waits", 32'(bus.b_ready), 32'd0);
    bus.a_valid = 1'b0;
    engine(3, 0, 4);
    exp_q.push_back(mk(0, 0, 1, 0, 24'h420202));
    wait_ready(1, 8, lat);
    bus.b_valid = 1'b0;
    engine(3, 0, 4);
    wait_idle(10);

    repeat (3) tick();
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sccb_arbiter.md
SCCB_ARBITER -- requirements
Module: sccb_arbiter

Interface
REQ-001 Parameter DEV_ADDR, default 8'h42, camera SCCB write address prefixed to every transaction.
REQ-002 Parameter MAX_RETRY, default 3, total transaction attempts before error.
REQ-003 Parameter GAP_CYC, default 8, idle cycles with eng_en low between a NACKed attempt and its retry.
REQ-004 Parameter TIMEOUT_CYC, default 4096, cycles in XFER without eng_end before abort.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 a_valid  in  1  config-sequencer request; held with a_data until a_ready.
REQ-008 a_data  in  16  {reg_addr[15:8], reg_value[7:0]} for requester A.
REQ-009 a_ready / a_done / a_err  out  1 each  acceptance / success / failure pulses to A.
REQ-010 b_valid, b_data[15:0], b_ready, b_done, b_err  same meanings for runtime requester B.
REQ-011 lock_a  in  1  high: B is never granted (boot phase).
REQ-012 eng_en  out  1  level enable to the SCCB transaction engine, held until eng_end.
REQ-013 eng_data  out  24  {DEV_ADDR, latched 16-bit request}; stable while eng_en high.
REQ-014 eng_end  in  1  engine transaction complete, one-cycle pulse.
REQ-015 eng_nack  in  1  sampled with eng_end; 1 = slave did not acknowledge.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, XFER, GAP, RESP; IDLE is the only state accepting requests.
REQ-018 IDLE, cycle N, any eligible valid: grant computed, x_ready pulses for one cycle at N+1, request latched, state XFER, eng_en high from N+1.
REQ-019 Arbitration: 2-way round robin; after reset A holds priority; after each grant priority passes to the other requester; lock_a=1 masks B regardless of pointer.
REQ-020 XFER: eng_en=1; on eng_end with eng_nack=0 -> RESP, owner x_done pulses one cycle.
REQ-021 XFER, eng_end with eng_nack=1: attempt counter increments; if counter reaches MAX_RETRY -> RESP with owner x_err pulse; else -> GAP.
REQ-022 GAP: eng_en=0 for exactly GAP_CYC cycles, then XFER with same eng_data.
REQ-023 XFER, TIMEOUT_CYC cycles elapsed without eng_end: eng_en low, owner x_err pulse, -> RESP.
REQ-024 eng_end and timeout expiry in same cycle: eng_end wins.
REQ-025 RESP lasts one cycle with eng_en=0, then IDLE; guarantees ≥2 low cycles of eng_en between transactions.
REQ-026 eng_end outside XFER is ignored.
REQ-027 x_done and x_err never assert together; exactly one of them per accepted request.
REQ-028 Attempt and timeout counters clear on every grant; timeout counter also clears on entering XFER from GAP.
REQ-029 Valid deasserted before ready: request is dropped, no pulses.

Reset
REQ-030 reset asserted: state IDLE, eng_en=0, eng_data=0, all ready/done/err pulses 0, busy=0, priority to A, counters 0.
REQ-031 reset mid-transaction aborts immediately; no done/err is issued for the aborted request.

Structure
REQ-032 Shared package sccb_pkg: FSM state enum, SCCB_DEV_ADDR (8'h42), REQ_W=16, ENG_W=24.
REQ-033 One sub-module sccb_rr_arbiter: 2-requester round robin with mask input and grant-advance strobe.

Verification
REQ-034 A only, a_data=16'h1204, engine ACK after 50 cycles -> eng_data=24'h421204, a_ready at N+1, a_done once, busy low after RESP.
REQ-035 A and B valid together after reset, lock_a=0 -> A served first, then B; next simultaneous request -> B first.
REQ-036 lock_a=1, B valid 1000 cycles -> no b_ready, eng_en stays 0; drop lock_a -> B served.
REQ-037 eng_nack=1 on every attempt, MAX_RETRY=3 -> three eng_en windows separated by 8 low cycles, one a_err, no a_done.
REQ-038 Engine never returns eng_end, TIMEOUT_CYC=64 -> eng_en falls after 64 cycles, x_err pulse; eng_end on cycle 64 instead -> x_done, no err.
REQ-039 reset asserted during XFER -> eng_en 0 asynchronously, no done/err; after release A regains priority.
